// File: rtl/barrel_shifter_pkg.sv
// Encodings shared by the pipelined barrel shifter, its stages and its stream interface.
package barrel_shifter_pkg;

  localparam logic [1:0] SHIFT_MODE_LOGICAL = 2'b00;
  localparam logic [1:0] SHIFT_MODE_ARITH   = 2'b01;
  localparam logic [1:0] SHIFT_MODE_ROTATE  = 2'b10;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Per-operation control that travels down the pipeline next to the data.
  typedef struct packed {
    logic       dir;
    logic [1:0] mode;
  } op_ctrl_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready stream bundle for the pipelined barrel shifter.
// BARREL_SHIFTER_STATUS_EN adds the out_zero/out_carry status signals.
interface pipelined_barrel_shifter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4
);
  localparam int SHIFT_W = $clog2(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic                  RbarL;
  logic [1:0]            mode;
  logic [SHIFT_W-1:0]    shift;
  logic [DATA_WIDTH-1:0] data_in;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic [TAG_WIDTH-1:0]  tag_out;
`ifdef BARREL_SHIFTER_STATUS_EN
  logic                  out_zero;
  logic                  out_carry;
`endif

  modport master (
    output in_valid, RbarL, mode, shift, data_in, tag_in, out_ready,
    input  in_ready, out_valid, data_out, tag_out
`ifdef BARREL_SHIFTER_STATUS_EN
    , out_zero, out_carry
`endif
  );

  modport slave (
    input  in_valid, RbarL, mode, shift, data_in, tag_in, out_ready,
    output in_ready, out_valid, data_out, tag_out
`ifdef BARREL_SHIFTER_STATUS_EN
    , out_zero, out_carry
`endif
  );

endinterface

// File: rtl/barrel_shifter_stage.sv
// One pipeline stage: conditionally shifts by 2^STAGE_IDX and registers the result with its sideband.
// BARREL_SHIFTER_STATUS_EN adds the carry chain and the zero flag.
module barrel_shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int STAGE_IDX  = 0,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          advance_i,
  input  logic                          valid_i,
  input  op_ctrl_t                      ctrl_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] shift_i,
  input  logic [TAG_WIDTH-1:0]          tag_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
`ifdef BARREL_SHIFTER_STATUS_EN
  input  logic                          carry_i,
  output logic                          carry_o,
  output logic                          zero_o,
`endif
  output logic                          valid_o,
  output op_ctrl_t                      ctrl_o,
  output logic [$clog2(DATA_WIDTH)-1:0] shift_o,
  output logic [TAG_WIDTH-1:0]          tag_o,
  output logic [DATA_WIDTH-1:0]         data_o
);
  localparam int SHIFT_W = $clog2(DATA_WIDTH);
  localparam int STEP    = 1 << STAGE_IDX;

  logic                  valid_d, valid_q;
  op_ctrl_t              ctrl_d, ctrl_q;
  logic [SHIFT_W-1:0]    shift_d, shift_q;
  logic [TAG_WIDTH-1:0]  tag_d, tag_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic [DATA_WIDTH-1:0] shifted_s;

  // Fixed-distance shift; the reserved mode falls through to the logical path.
  always_comb begin
    shifted_s = data_i;
    if (ctrl_i.dir == DIR_LEFT) begin
      case (ctrl_i.mode)
        SHIFT_MODE_ROTATE: shifted_s = (data_i << STEP) | (data_i >> (DATA_WIDTH - STEP));
        default:           shifted_s = data_i << STEP;
      endcase
    end else begin
      case (ctrl_i.mode)
        SHIFT_MODE_ARITH:  shifted_s = $unsigned($signed(data_i) >>> STEP);
        SHIFT_MODE_ROTATE: shifted_s = (data_i >> STEP) | (data_i << (DATA_WIDTH - STEP));
        default:           shifted_s = data_i >> STEP;
      endcase
    end
  end

  // Load on advance, otherwise hold so the whole pipe freezes together.
  always_comb begin
    if (advance_i) begin
      valid_d = valid_i;
      ctrl_d  = ctrl_i;
      shift_d = shift_i;
      tag_d   = tag_i;
      data_d  = shift_i[STAGE_IDX] ? shifted_s : data_i;
    end else begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      shift_d = shift_q;
      tag_d   = tag_q;
      data_d  = data_q;
    end
  end

`ifdef BARREL_SHIFTER_STATUS_EN
  localparam bit IS_LAST = (STAGE_IDX == SHIFT_W - 1);

  logic out_bit_s;
  logic carry_d, carry_q;
  logic zero_d, zero_q;

  // The highest stage that actually shifts sees the overall last bit to leave the word.
  always_comb begin
    if (ctrl_i.dir == DIR_LEFT) begin
      out_bit_s = data_i[DATA_WIDTH-STEP];
    end else begin
      out_bit_s = data_i[STEP-1];
    end
    if (advance_i) begin
      carry_d = shift_i[STAGE_IDX] ? out_bit_s : carry_i;
    end else begin
      carry_d = carry_q;
    end
    zero_d = IS_LAST ? (data_d == {DATA_WIDTH{1'b0}}) : 1'b0;
  end
`endif

  // Stage pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '{dir: 1'b0, mode: 2'b00};
      shift_q <= {SHIFT_W{1'b0}};
      tag_q   <= {TAG_WIDTH{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
`ifdef BARREL_SHIFTER_STATUS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      shift_q <= shift_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
`ifdef BARREL_SHIFTER_STATUS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign shift_o = shift_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;
`ifdef BARREL_SHIFTER_STATUS_EN
  assign carry_o = carry_q;
  assign zero_o  = zero_q;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, valid/ready in and out, global stall.
// BARREL_SHIFTER_STATUS_EN adds registered out_zero/out_carry.
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipelined_barrel_shifter_if.slave   bs
);
  localparam int SHIFT_W = $clog2(DATA_WIDTH);

  logic                  advance_s;
  logic                  valid_s [0:SHIFT_W];
  op_ctrl_t              ctrl_s  [0:SHIFT_W];
  logic [SHIFT_W-1:0]    shift_s [0:SHIFT_W];
  logic [TAG_WIDTH-1:0]  tag_s   [0:SHIFT_W];
  logic [DATA_WIDTH-1:0] data_s  [0:SHIFT_W];
  op_ctrl_t              ctrl_unused_s;
  logic [SHIFT_W-1:0]    shift_unused_s;
`ifdef BARREL_SHIFTER_STATUS_EN
  logic                  carry_s [0:SHIFT_W];
  logic [SHIFT_W-1:0]    zero_s;
  logic [SHIFT_W-1:0]    zero_unused_s;
`endif

  // Bubbles are kept; the only stall condition is a result the sink refuses.
  assign advance_s = !valid_s[SHIFT_W] || bs.out_ready;

  assign valid_s[0] = bs.in_valid;
  assign ctrl_s[0]  = '{dir: bs.RbarL, mode: bs.mode};
  assign shift_s[0] = bs.shift;
  assign tag_s[0]   = bs.tag_in;
  assign data_s[0]  = bs.data_in;
`ifdef BARREL_SHIFTER_STATUS_EN
  assign carry_s[0] = 1'b0;
`endif

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    barrel_shifter_stage #(
      .STAGE_IDX  (k),
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance_s),
      .valid_i   (valid_s[k]),
      .ctrl_i    (ctrl_s[k]),
      .shift_i   (shift_s[k]),
      .tag_i     (tag_s[k]),
      .data_i    (data_s[k]),
`ifdef BARREL_SHIFTER_STATUS_EN
      .carry_i   (carry_s[k]),
      .carry_o   (carry_s[k+1]),
      .zero_o    (zero_s[k]),
`endif
      .valid_o   (valid_s[k+1]),
      .ctrl_o    (ctrl_s[k+1]),
      .shift_o   (shift_s[k+1]),
      .tag_o     (tag_s[k+1]),
      .data_o    (data_s[k+1])
    );
  end

  // Control that has left the final stage has no further consumer.
  assign ctrl_unused_s  = ctrl_s[SHIFT_W];
  assign shift_unused_s = shift_s[SHIFT_W];

  assign bs.in_ready  = advance_s;
  assign bs.out_valid = valid_s[SHIFT_W];
  assign bs.data_out  = data_s[SHIFT_W];
  assign bs.tag_out   = tag_s[SHIFT_W];
`ifdef BARREL_SHIFTER_STATUS_EN
  assign zero_unused_s = zero_s;
  assign bs.out_zero   = zero_s[SHIFT_W-1];
  assign bs.out_carry  = carry_s[SHIFT_W];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (DATA_WIDTH=8); status outputs checked when BARREL_SHIFTER_STATUS_EN is defined.
module tb_pipelined_barrel_shifter;
  import barrel_shifter_pkg::*;

  localparam int DW = 8;
  localparam int TW = 4;
  localparam int SW = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          carry;
  } exp_t;

  typedef struct {
    logic          dir;
    logic [1:0]    mode;
    logic [SW-1:0] sh;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          carry;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  pipelined_barrel_shifter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bs ();

  pipelined_barrel_shifter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bs    (bs)
  );

  always #5 clk = ~clk;

  // Bit-by-bit reference: each output bit names its source bit.
  function automatic exp_t model(input logic dir, input logic [1:0] mode, input logic [SW-1:0] sh,
                                 input logic [DW-1:0] d, input logic [TW-1:0] tag);
    exp_t e;
    int   src;
    e.tag = tag;
    e.data = 8'h00;
    e.carry = 1'b0;
    for (int i = 0; i < DW; i++) begin
      src = (dir == DIR_RIGHT) ? i + int'(sh) : i - int'(sh);
      if (mode == SHIFT_MODE_ROTATE) e.data[i] = d[(src + DW) % DW];
      else if (src >= 0 && src < DW) e.data[i] = d[src];
      else if (dir == DIR_RIGHT && mode == SHIFT_MODE_ARITH) e.data[i] = d[DW-1];
      else e.data[i] = 1'b0;
    end
    if (sh != 3'd0) e.carry = (dir == DIR_RIGHT) ? d[int'(sh)-1] : d[DW-int'(sh)];
    return e;
  endfunction

  task automatic drive(input logic v, input logic dir, input logic [1:0] mode, input logic [SW-1:0] sh,
                       input logic [DW-1:0] d, input logic [TW-1:0] tag);
    bs.in_valid = v;
    bs.RbarL    = dir;
    bs.mode     = mode;
    bs.shift    = sh;
    bs.data_in  = d;
    bs.tag_in   = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bs.out_ready = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bs.out_valid !== 1'b0 || bs.data_out !== 8'h00 || bs.tag_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%h tag=%h exp 0/00/0", bs.out_valid, bs.data_out, bs.tag_out);
    end
`ifdef BARREL_SHIFTER_STATUS_EN
    checks++;
    if (bs.out_zero !== 1'b0 || bs.out_carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got zero=%b carry=%b exp 0/0", bs.out_zero, bs.out_carry);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bs.in_ready !== 1'b1 || bs.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got in_ready=%b out_valid=%b exp 1/0", bs.in_ready, bs.out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t tbl [7];
    exp_t e;
    int   lat;
    tbl = '{
      '{DIR_RIGHT, SHIFT_MODE_LOGICAL, 3'd3, 8'hB4, 8'h16, 1'b1},
      '{DIR_RIGHT, SHIFT_MODE_ARITH,   3'd2, 8'hB4, 8'hED, 1'b0},
      '{DIR_LEFT,  SHIFT_MODE_ROTATE,  3'd1, 8'h81, 8'h03, 1'b1},
      '{DIR_RIGHT, SHIFT_MODE_ROTATE,  3'd7, 8'h01, 8'h02, 1'b0},
      '{DIR_LEFT,  SHIFT_MODE_ARITH,   3'd1, 8'hB4, 8'h68, 1'b1},
      '{DIR_RIGHT, 2'b11,              3'd3, 8'hB4, 8'h16, 1'b1},
      '{DIR_LEFT,  SHIFT_MODE_LOGICAL, 3'd7, 8'hFF, 8'h80, 1'b1}
    };
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      bs.out_ready = 1'b1;
      drive(1'b1, tbl[v].dir, tbl[v].mode, tbl[v].sh, tbl[v].din, 4'(v + 1));
      e.data = tbl[v].dout;
      e.tag = 4'(v + 1);
      e.carry = tbl[v].carry;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
      lat = 1;
      while (!bs.out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != SW) begin
        failures++;
        $display("FAIL directed_latency vec=%0d got=%0d exp=%0d", v, lat, SW);
      end
      e = sb.pop_front();
      checks++;
      if (bs.data_out !== e.data || bs.tag_out !== e.tag) begin
        failures++;
        $display("FAIL directed_result vec=%0d got=%h/%h exp=%h/%h", v, bs.data_out, bs.tag_out, e.data, e.tag);
      end
`ifdef BARREL_SHIFTER_STATUS_EN
      checks++;
      if (bs.out_carry !== e.carry || bs.out_zero !== (e.data == 8'h00)) begin
        failures++;
        $display("FAIL directed_status vec=%0d got carry=%b zero=%b exp carry=%b", v, bs.out_carry, bs.out_zero, e.carry);
      end
`endif
    end
  endtask

  task automatic test_shift_zero();
    exp_t          e;
    logic [DW-1:0] d;
    int            sent = 0;
    int            got = 0;
    int            cyc = 0;
    bs.out_ready = 1'b1;
    while (got < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bs.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL zero_unexpected_output data=%h", bs.data_out);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bs.data_out !== e.data || bs.tag_out !== e.tag) begin
            failures++;
            $display("FAIL zero_shift_result got=%h/%h exp=%h/%h", bs.data_out, bs.tag_out, e.data, e.tag);
          end
`ifdef BARREL_SHIFTER_STATUS_EN
          checks++;
          if (bs.out_carry !== 1'b0 || bs.out_zero !== (e.data == 8'h00)) begin
            failures++;
            $display("FAIL zero_shift_status got carry=%b zero=%b exp carry=0", bs.out_carry, bs.out_zero);
          end
`endif
          got++;
        end
      end
      if (sent < 8 && bs.in_ready) begin
        d = 8'($urandom);
        drive(1'b1, 1'(sent % 2), 2'(sent / 2), 3'd0, d, 4'(sent + 8));
        e.data = d;
        e.tag = 4'(sent + 8);
        e.carry = 1'b0;
        sb.push_back(e);
        sent++;
      end else begin
        drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
      end
    end
    checks++;
    if (got != 8 || sb.size() != 0) begin
      failures++;
      $display("FAIL zero_shift_count got=%0d exp=8 leftover=%0d", got, sb.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t          e, pend_e;
    logic [DW-1:0] held_d, d;
    logic [TW-1:0] held_t;
    logic          dir;
    logic [1:0]    mode;
    logic [SW-1:0] sh;
    bit            pending = 1'b0;
    bit            stalled_once = 1'b0;
    int            stall = 0;
    int            sent = 0;
    int            got = 0;
    int            cyc = 0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bs.out_valid && !stalled_once) begin
        stalled_once = 1'b1;
        stall = 5;
        held_d = bs.data_out;
        held_t = bs.tag_out;
      end
      bs.out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        checks++;
        if (bs.in_ready !== 1'b0 || bs.out_valid !== 1'b1 || bs.data_out !== held_d || bs.tag_out !== held_t) begin
          failures++;
          $display("FAIL bp_stall_hold got ready=%b valid=%b data=%h tag=%h exp 0/1/%h/%h",
                   bs.in_ready, bs.out_valid, bs.data_out, bs.tag_out, held_d, held_t);
        end
        stall--;
      end else if (bs.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bp_unexpected_output data=%h tag=%h", bs.data_out, bs.tag_out);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bs.data_out !== e.data || bs.tag_out !== e.tag) begin
            failures++;
            $display("FAIL bp_result got=%h/%h exp=%h/%h", bs.data_out, bs.tag_out, e.data, e.tag);
          end
`ifdef BARREL_SHIFTER_STATUS_EN
          checks++;
          if (bs.out_carry !== e.carry || bs.out_zero !== (e.data == 8'h00)) begin
            failures++;
            $display("FAIL bp_status got carry=%b zero=%b exp carry=%b", bs.out_carry, bs.out_zero, e.carry);
          end
`endif
          got++;
        end
      end
      if (!pending && sent < 10) begin
        dir = 1'($urandom);
        mode = 2'($urandom);
        sh = 3'($urandom);
        d = 8'($urandom);
        pend_e = model(dir, mode, sh, d, 4'(sent));
        drive(1'b1, dir, mode, sh, d, 4'(sent));
        pending = 1'b1;
      end else if (!pending) begin
        drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
      end
      if (pending && bs.in_ready) begin
        sb.push_back(pend_e);
        sent++;
        pending = 1'b0;
      end
    end
    checks++;
    if (got != 10 || sb.size() != 0 || !stalled_once) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=10 leftover=%0d stalled=%0b", got, sb.size(), stalled_once);
    end
    drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
    repeat (4) @(negedge clk);
    checks++;
    if (bs.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_duplicate got out_valid=%b exp 0", bs.out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    bit   seen = 1'b0;
    int   cyc = 0;
    sb.delete();
    @(negedge clk);
    bs.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DIR_LEFT, SHIFT_MODE_LOGICAL, 3'(i), 8'h5A, 4'(i + 1));
      @(negedge clk);
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
    @(negedge clk);
    checks++;
    if (bs.out_valid !== 1'b0 || bs.data_out !== 8'h00) begin
      failures++;
      $display("FAIL midreset_flush got valid=%b data=%h exp 0/00", bs.out_valid, bs.data_out);
    end
    rst_n = 1'b1;
    bs.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bs.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_ghost got out_valid=1 exp 0");
    end
    drive(1'b1, DIR_RIGHT, SHIFT_MODE_LOGICAL, 3'd4, 8'hF0, 4'hA);
    e.data = 8'h0F;
    e.tag = 4'hA;
    e.carry = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
    while (!bs.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (bs.out_valid !== 1'b1 || bs.data_out !== e.data || bs.tag_out !== e.tag) begin
      failures++;
      $display("FAIL midreset_new_op got valid=%b data=%h tag=%h exp 1/%h/%h", bs.out_valid, bs.data_out, bs.tag_out, e.data, e.tag);
    end
`ifdef BARREL_SHIFTER_STATUS_EN
    checks++;
    if (bs.out_carry !== e.carry || bs.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL midreset_status got carry=%b zero=%b exp 0/0", bs.out_carry, bs.out_zero);
    end
`endif
  endtask

  initial begin
    bs.out_ready = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 4'h0);
    test_reset();
    test_directed();
    test_shift_zero();
    test_backpressure();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
